// File: rtl/fifo_pkg.sv
// Shared definitions for the async_fifo stream writer and reader.
// Word layout is {last, cnt, data} with data in the LSBs.
package fifo_pkg;

  localparam int DEF_IN_WIDTH = 8;
  localparam int DEF_RATIO    = 4;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int cnt_lsb(input int iw, input int ratio);
    return iw * ratio;
  endfunction

  function automatic int last_bit(input int iw, input int ratio);
    return iw * ratio + clog2(ratio);
  endfunction

  localparam int DATA_LSB = 0;
  localparam int CNT_LSB  = cnt_lsb(DEF_IN_WIDTH, DEF_RATIO);
  localparam int LAST_BIT = last_bit(DEF_IN_WIDTH, DEF_RATIO);

endpackage

// File: rtl/fifo_stream_writer.sv
// Packs a narrow byte stream into wide async_fifo words.
// One holding register decouples packing from FIFO back-pressure.
module fifo_stream_writer
  import fifo_pkg::*;
#(
  parameter int IN_WIDTH = DEF_IN_WIDTH,
  parameter int RATIO = DEF_RATIO,
  localparam int CW = clog2(RATIO),
  localparam int OUT_WIDTH = IN_WIDTH * RATIO + CW + 1
) (
  input  logic                 wclk,
  input  logic                 wrstn,
  input  logic                 s_valid,
  input  logic [IN_WIDTH-1:0]  s_data,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic                 fifo_wr,
  output logic [OUT_WIDTH-1:0] fifo_din,
  input  logic                 fifo_full,
  output logic                 busy
);

  localparam int PW    = IN_WIDTH * RATIO;
  localparam int C_LSB = cnt_lsb(IN_WIDTH, RATIO);
  localparam int L_BIT = last_bit(IN_WIDTH, RATIO);

  logic [PW-1:0]        pack;
  logic [CW-1:0]        lane;
  logic [OUT_WIDTH-1:0] out_word;
  logic                 out_valid;

  logic                 acc;
  logic                 complete;
  logic [PW-1:0]        merged;
  logic [OUT_WIDTH-1:0] word_next;
  logic [CW-1:0]        lane_next;
  logic                 ov_next;

  assign s_ready  = !(out_valid && fifo_full);
  assign fifo_wr  = out_valid && !fifo_full;
  assign fifo_din = out_word;
  assign acc      = s_valid && s_ready;
  assign complete = acc &&
                    ((lane == CW'(RATIO - 1)) || s_last);

  // Merge the current beat into its lane; lanes above it read as zero.
  always_comb begin
    merged = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (CW'(i) < lane)
        merged[i*IN_WIDTH +: IN_WIDTH] = pack[i*IN_WIDTH +: IN_WIDTH];
      else if (CW'(i) == lane)
        merged[i*IN_WIDTH +: IN_WIDTH] = s_data;
    end
  end

  // Next-state values for the word, lane and holding flag.
  always_comb begin
    word_next = '0;
    word_next[PW-1:0] = merged;
    word_next[C_LSB +: CW] = lane;
    word_next[L_BIT] = s_last;
    lane_next = lane;
    if (acc)
      lane_next = complete ? '0 : lane + CW'(1);
    ov_next = out_valid;
    if (complete)
      ov_next = 1'b1;
    else if (fifo_wr)
      ov_next = 1'b0;
  end

  // Packing side: collect beats lane by lane.
  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      pack <= '0;
      lane <= '0;
    end else if (acc) begin
      pack <= complete ? '0 : merged;
      lane <= lane_next;
    end
  end

  // Output side: hold a finished word until the FIFO takes it.
  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      out_word  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (complete)
        out_word <= word_next;
      out_valid <= ov_next;
      busy      <= ov_next || (lane_next != '0);
    end
  end

endmodule

// File: tb/tb_fifo_stream_writer.sv
// Directed bench for fifo_stream_writer (IN_WIDTH=8, RATIO=4).
// Vector table plus hand-written stall, stream and reset sequences.
module tb_fifo_stream_writer;

  logic        wclk;
  logic        wrstn;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_last;
  logic        s_ready;
  logic        fifo_wr;
  logic [34:0] fifo_din;
  logic        fifo_full;
  logic        busy;

  int total;
  int bad;

  fifo_stream_writer #(
    .IN_WIDTH(8),
    .RATIO(4)
  ) dut (
    .wclk(wclk),
    .wrstn(wrstn),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_last(s_last),
    .s_ready(s_ready),
    .fifo_wr(fifo_wr),
    .fifo_din(fifo_din),
    .fifo_full(fifo_full),
    .busy(busy)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        f;
    logic        rdy;
    logic        wr;
    logic [34:0] din;
    logic        bsy;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(
    logic v, logic [7:0] d, logic l, logic f,
    logic rdy, logic wr, logic [34:0] din, logic bsy);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.f = f;
    r.rdy = rdy; r.wr = wr; r.din = din; r.bsy = bsy;
    return r;
  endfunction

  task automatic chk(string nm, logic [34:0] act, logic [34:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(logic v, logic [7:0] d, logic l, logic f);
    s_valid   = v;
    s_data    = d;
    s_last    = l;
    fifo_full = f;
  endtask

  task automatic next_cycle();
    @(posedge wclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [34:0] held;
    logic [34:0] exp_w;
    int nwr;
    total = 0;
    bad = 0;
    wrstn = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #3;
    chk("rst_ready", 35'(s_ready), 35'(1));
    chk("rst_wr", 35'(fifo_wr), 35'(0));
    chk("rst_din", fifo_din, 35'(0));
    chk("rst_busy", 35'(busy), 35'(0));
    @(negedge wclk);
    wrstn = 1'b1;
    next_cycle();

    // Full word, short packet, single-beat packet with concurrent drain
    tbl[0]  = mk(1, 8'h11, 0, 0, 1, 0, 35'h0, 0);
    tbl[1]  = mk(1, 8'h22, 0, 0, 1, 0, 35'h0, 1);
    tbl[2]  = mk(1, 8'h33, 0, 0, 1, 0, 35'h0, 1);
    tbl[3]  = mk(1, 8'h44, 0, 0, 1, 0, 35'h0, 1);
    tbl[4]  = mk(0, 8'h00, 0, 0, 1, 1, 35'h344332211, 1);
    tbl[5]  = mk(0, 8'h00, 0, 0, 1, 0, 35'h344332211, 0);
    tbl[6]  = mk(1, 8'hA1, 0, 0, 1, 0, 35'h344332211, 0);
    tbl[7]  = mk(1, 8'hA2, 1, 0, 1, 0, 35'h344332211, 1);
    tbl[8]  = mk(1, 8'hB0, 0, 0, 1, 1, 35'h50000A2A1, 1);
    tbl[9]  = mk(1, 8'hB1, 1, 0, 1, 0, 35'h50000A2A1, 1);
    tbl[10] = mk(0, 8'h00, 0, 0, 1, 1, 35'h50000B1B0, 1);
    tbl[11] = mk(0, 8'h00, 0, 0, 1, 0, 35'h50000B1B0, 0);
    tbl[12] = mk(1, 8'h7F, 1, 0, 1, 0, 35'h50000B1B0, 0);
    tbl[13] = mk(1, 8'h5A, 1, 0, 1, 1, 35'h40000007F, 1);
    tbl[14] = mk(0, 8'h00, 0, 0, 1, 1, 35'h40000005A, 1);
    tbl[15] = mk(0, 8'h00, 0, 0, 1, 0, 35'h40000005A, 0);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].f);
      @(negedge wclk);
      chk($sformatf("vec%0d_ready", i), 35'(s_ready), 35'(tbl[i].rdy));
      chk($sformatf("vec%0d_wr", i), 35'(fifo_wr), 35'(tbl[i].wr));
      chk($sformatf("vec%0d_din", i), fifo_din, tbl[i].din);
      chk($sformatf("vec%0d_busy", i), 35'(busy), 35'(tbl[i].bsy));
      next_cycle();
    end

    // Full stall: word completes while the FIFO is full
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hC1 + 8'(i), 1'b0, 1'b1);
      @(negedge wclk);
      chk("stall_fill_ready", 35'(s_ready), 35'(1));
      next_cycle();
    end
    held = 35'h3C4C3C2C1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'hD0, 1'b0, 1'b1);
      @(negedge wclk);
      chk("stall_wr", 35'(fifo_wr), 35'(0));
      chk("stall_ready", 35'(s_ready), 35'(0));
      chk("stall_din", fifo_din, held);
      next_cycle();
    end
    drive(1'b1, 8'hD0, 1'b0, 1'b0);
    @(negedge wclk);
    chk("release_wr", 35'(fifo_wr), 35'(1));
    chk("release_ready", 35'(s_ready), 35'(1));
    chk("release_din", fifo_din, held);
    next_cycle();
    drive(1'b1, 8'hD1, 1'b1, 1'b0);
    @(negedge wclk);
    chk("release_once", 35'(fifo_wr), 35'(0));
    chk("release_busy", 35'(busy), 35'(1));
    next_cycle();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge wclk);
    chk("after_stall_wr", 35'(fifo_wr), 35'(1));
    chk("after_stall_din", fifo_din, 35'h50000D1D0);
    next_cycle();

    // Streaming: 16 beats back to back
    nwr = 0;
    for (int c = 0; c < 20; c++) begin
      drive(c < 16, 8'(c), 1'b0, 1'b0);
      @(negedge wclk);
      chk($sformatf("stream%0d_ready", c), 35'(s_ready), 35'(1));
      chk($sformatf("stream%0d_wr", c), 35'(fifo_wr),
          35'(c >= 4 && c <= 16 && (c % 4) == 0));
      if (fifo_wr) begin
        exp_w = {1'b0, 2'b11,
                 8'(4*nwr+3), 8'(4*nwr+2), 8'(4*nwr+1), 8'(4*nwr)};
        chk($sformatf("stream_word%0d", nwr), fifo_din, exp_w);
        nwr++;
      end
      next_cycle();
    end
    chk("stream_count", 35'(nwr), 35'(4));

    // Mid-word reset
    drive(1'b1, 8'hEE, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 8'hEF, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    wrstn = 1'b0;
    #1;
    chk("mrst_wr", 35'(fifo_wr), 35'(0));
    chk("mrst_din", fifo_din, 35'(0));
    chk("mrst_busy", 35'(busy), 35'(0));
    chk("mrst_ready", 35'(s_ready), 35'(1));
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    wrstn = 1'b1;
    next_cycle();
    @(negedge wclk);
    chk("post_rst_busy", 35'(busy), 35'(0));
    chk("post_rst_wr", 35'(fifo_wr), 35'(0));
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(i + 1), 1'b0, 1'b0);
      next_cycle();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge wclk);
    chk("post_rst_wr2", 35'(fifo_wr), 35'(1));
    chk("post_rst_din", fifo_din, 35'h304030201);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_stream_writer.md
# fifo_stream_writer

Write-side producer for the team's `async_fifo`. It accepts a narrow valid/ready byte stream in the `wclk` domain and packs `RATIO` beats into one wide word. The word is pushed into the FIFO write port (`wr`/`din`/`full`) only when the FIFO is not full. Packet boundaries (`s_last`) and partial-word lane counts travel inside the FIFO word so the read side can unpack them.

## Interface
- `IN_WIDTH`, 8: width of one input beat.
- `RATIO`, 4: beats per FIFO word; must be a power of 2 and at least 2.
- `CW`, clog2(`RATIO`): width of the lane-count field (derived, not overridable).
- `OUT_WIDTH`, `IN_WIDTH*RATIO + CW + 1`: FIFO word width (derived). The FIFO instance must use `DATA_WIDTH = OUT_WIDTH`.

Ports:
- `wclk`  in  1  write-domain clock.
- `wrstn`  in  1  reset, asynchronous, active-low.
- `s_valid`  in  1  input beat valid.
- `s_data`  in  `IN_WIDTH`  input beat.
- `s_last`  in  1  final beat of a packet.
- `s_ready`  out  1  beat accepted when `s_valid && s_ready`.
- `fifo_wr`  out  1  FIFO write strobe; connects to FIFO `wr`.
- `fifo_din`  out  `OUT_WIDTH`  FIFO word, laid out as {last, cnt, data}.
- `fifo_full`  in  1  FIFO `full`.
- `busy`  out  1  a partial word or an undelivered word is held.

## Operation
- **State held:**
  - pack register `pack` (`IN_WIDTH*RATIO` bits).
  - lane counter `lane` (`CW` bits).
  - output holding register `out_word`, with flag `out_valid`.
- **Accept condition:** `acc = s_valid && s_ready`, where `s_ready = !(out_valid && fifo_full)`.
  - `s_ready` is combinational from `fifo_full`, which is glitch-free because it is registered-derived inside the FIFO.
- **Lane placement:** an accepted beat is written to `pack[lane*IN_WIDTH +: IN_WIDTH]`. Lane 0 occupies the LSBs.
- **Completing beat:** `acc && (lane == RATIO-1 || s_last)`. On a completing beat:
  - `out_word.data` takes `pack` with the current beat merged in. Lanes above `lane` are forced to 0.
  - `out_word.cnt` takes `lane`, i.e. number of valid lanes minus 1.
  - `out_word.last` takes `s_last`.
  - `out_valid` is set to 1.
  - `lane` is set to 0 and `pack` is cleared.
- **Non-completing beat:** `lane` increments by 1.
- **Drain:** `fifo_wr = out_valid && !fifo_full`, and `fifo_din = out_word`.
  - When `fifo_wr` is high, `out_valid` clears at the next edge unless a completing beat loads a new word in the same cycle, in which case `out_valid` stays 1.
- **Stall:** while `out_valid && fifo_full`:
  - `s_ready` is 0.
  - `out_word` is held stable.
  - `fifo_wr` is 0.
- **busy** `= out_valid || (lane != 0)`.
- **Packets:** each packet ends with a word where last = 1. A packet never shares a word with the next packet. A single-beat packet gives cnt = 0, last = 1.
- **Simultaneous events:** a completing beat in the same cycle as a drain overwrites `out_word` after the write. No word is lost and none is duplicated.
- **Reset** (asynchronous, any time, including mid-word):
  - `pack`, `lane`, `out_word` and `out_valid` go to 0.
  - Partial and pending words are discarded.
  - Output values during and after reset: `fifo_wr` = 0, `fifo_din` = 0, `busy` = 0, `s_ready` = 1.
  - The producer must hold `s_valid` low during reset.

## Timing
- **Throughput:** 1 beat per cycle sustained while `fifo_full` = 0. `s_ready` never drops in that case.
- **Latency:** a completing beat accepted at edge N gives `fifo_wr` = 1 during cycle N+1, provided `fifo_full` is 0 in that cycle.
- **Back-pressure:** `fifo_full` rising in cycle C gives `s_ready` = 0 in cycle C, but only if `out_valid` is 1. Non-full partial packing continues otherwise.
- **Outputs:** `fifo_din` and `busy` are registered. `fifo_wr` and `s_ready` are single-gate combinational outputs.

## Structure
- Shared package (`fifo_pkg`) holds:
  - the `clog2` function;
  - field offsets `DATA_LSB = 0`, `CNT_LSB = IN_WIDTH*RATIO`, and `LAST_BIT = OUT_WIDTH-1`.
  - The matching read-side unpacker uses the same package.
- Single module with no sub-module. Packing and output holding are two always blocks in one file.
- Integration: instantiated directly beside `async_fifo`, sharing `wclk` and the synchronized `wrstn`.

## Test plan
Parameters for all scenarios: `IN_WIDTH` = 8, `RATIO` = 4.
1. **Full word:** beats 0x11, 0x22, 0x33, 0x44 with `s_last` = 0 and `fifo_full` = 0 → one `fifo_wr` pulse, 1 cycle after the 4th beat. `fifo_din` has data 0x44332211, cnt = 3, last = 0.
2. **Short packet:** beats 0xA1, then 0xA2 with `s_last` = 1 → data 0x0000A2A1, cnt = 1, last = 1. The next beat 0xB0 lands in lane 0.
3. **Full stall:** complete a word while `fifo_full` = 1 for 5 cycles → `fifo_wr` = 0, `s_ready` = 0 and `fifo_din` stable throughout. On release, exactly one write of the same word and `s_ready` = 1 in the same cycle.
4. **Streaming:** 16 continuous beats 0x00..0x0F with no full → 4 writes, the first being 0x03020100. `s_ready` stays 1 throughout and the writes are contiguous.
5. **Mid-word reset:** 2 beats 0xEE, 0xEF, then assert `wrstn` low for 2 cycles → no write and `busy` = 0. The following beats 0x01..0x04 give 0x04030201 with no stale lanes.
6. **Single-beat packet plus concurrent drain:** `s_last` on lane 0 with 0x7F gives data 0x0000007F, cnt = 0, last = 1. A second completing word arriving in the draining cycle is written the next cycle, with no loss.
